// File: rtl/cu_pkg.sv
// Shared encodings and stage control bundle for the pipelined control unit.
package cu_pkg;

    // Supported major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operations
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    // Writeback source
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // PC source
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    // Operand forwarding source
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       mem_read;
        logic       byte_op;
        logic       branch;
        logic       branch_ne;
        logic       jal;
        logic       jalr;
        logic       alu_src;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_BUBBLE = '0;

    // funct3/funct7[5] to ALU op; only R-type uses bit 30 to pick sub
    function automatic logic [3:0] alu_decode(logic [2:0] funct3, logic alt, logic is_r);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational ID-stage decoder: controls, immediate format, register fields, legality.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ALU_CTRL_WIDTH = 4
) (
    input  logic [INSTR_WIDTH-1:0]    instr,
    input  logic                      instr_valid,
    output stage_ctrl_t               ctrl,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    output logic [2:0]                imm_src,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      rs1_used,
    output logic                      rs2_used,
    output logic                      illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       legal;
    logic [3:0] alu_op;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    assign rs1    = REG_ADDR_WIDTH'(instr[19:15]);
    assign rs2    = REG_ADDR_WIDTH'(instr[24:20]);
    assign rd     = REG_ADDR_WIDTH'(instr[11:7]);
    assign unused_instr = ^{instr[INSTR_WIDTH-1:31], instr[29:25]};

    // Opcode decode; invalid or unsupported instructions decode to a bubble
    always_comb begin
        ctrl     = CTRL_BUBBLE;
        alu_op   = ALU_ADD;
        imm_src  = IMM_I;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                alu_op         = alu_decode(funct3, alt, 1'b1);
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
                alu_op         = alu_decode(funct3, alt, 1'b0);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.mem_read   = 1'b1;
                ctrl.byte_op    = (funct3 == 3'b100);
                ctrl.alu_src    = 1'b1;
                rs1_used        = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.byte_op   = (funct3 == 3'b000);
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = funct3[0];
                alu_op         = ALU_SUB;
                imm_src        = IMM_B;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jal        = 1'b1;
                imm_src         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                rs1_used        = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_op         = ALU_PASSB;
                imm_src        = IMM_U;
            end
            default: legal = 1'b0;
        endcase
        if (!instr_valid || !legal) begin
            ctrl     = CTRL_BUBBLE;
            alu_op   = ALU_ADD;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end

    assign illegal  = instr_valid & ~legal;
    assign alu_ctrl = ALU_CTRL_WIDTH'(alu_op);

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// branch resolution in EX, hazard stalls/flushes and operand forwarding.
module pipelined_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ALU_CTRL_WIDTH = 4,
    parameter bit          FORWARDING     = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INSTR_WIDTH-1:0]    instr_id_i,
    input  logic                      instr_valid_i,
    input  logic                      zero_ex_i,
    output logic [2:0]                ImmSrc_id_o,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl_ex_o,
    output logic                      ALUSrc_ex_o,
    output logic [1:0]                ForwardA_ex_o,
    output logic [1:0]                ForwardB_ex_o,
    output logic [1:0]                PCSrc_ex_o,
    output logic                      MemWrite_mem_o,
    output logic                      ByteOp_mem_o,
    output logic                      RegWrite_wb_o,
    output logic [1:0]                ResultSrc_wb_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_wb_o,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      flush_id_o,
    output logic                      flush_ex_o,
    output logic                      illegal_id_o
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    // ID stage
    stage_ctrl_t               ctrl_id;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_id;
    reg_addr_t                 rs1_id, rs2_id, rd_id;
    logic                      rs1_used_id, rs2_used_id;

    // EX stage
    stage_ctrl_t               ctrl_ex;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_ex;
    reg_addr_t                 rs1_ex, rs2_ex, rd_ex;

    // MEM stage
    logic                      reg_write_mem, mem_write_mem, byte_op_mem;
    logic [1:0]                result_src_mem;
    reg_addr_t                 rd_mem;

    // WB stage
    logic                      reg_write_wb;
    logic [1:0]                result_src_wb;
    reg_addr_t                 rd_wb;

    logic                      taken, load_use, raw_ex, raw_mem, hazard, bubble_id;
    logic [1:0]                pc_src, fwd_a, fwd_b;

    cu_decoder #(
        .INSTR_WIDTH    (INSTR_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .ALU_CTRL_WIDTH (ALU_CTRL_WIDTH)
    ) u_decoder (
        .instr       (instr_id_i),
        .instr_valid (instr_valid_i),
        .ctrl        (ctrl_id),
        .alu_ctrl    (alu_ctrl_id),
        .imm_src     (ImmSrc_id_o),
        .rs1         (rs1_id),
        .rs2         (rs2_id),
        .rd          (rd_id),
        .rs1_used    (rs1_used_id),
        .rs2_used    (rs2_used_id),
        .illegal     (illegal_id_o)
    );

    // A used source register depends on a writer; x0 never matches
    function automatic logic rs_hit(reg_addr_t rs, logic used, reg_addr_t rd);
        return used && (rd != '0) && (rs == rd);
    endfunction

    // Branch resolution and hazard detection
    always_comb begin
        taken = (ctrl_ex.branch & (zero_ex_i ^ ctrl_ex.branch_ne)) | ctrl_ex.jal | ctrl_ex.jalr;
        if (ctrl_ex.jalr) begin
            pc_src = PC_JALR;
        end else if (taken) begin
            pc_src = PC_BRANCH;
        end else begin
            pc_src = PC_PLUS4;
        end
        load_use = ctrl_ex.mem_read &
                   (rs_hit(rs1_id, rs1_used_id, rd_ex) | rs_hit(rs2_id, rs2_used_id, rd_ex));
        raw_ex   = ctrl_ex.reg_write &
                   (rs_hit(rs1_id, rs1_used_id, rd_ex) | rs_hit(rs2_id, rs2_used_id, rd_ex));
        raw_mem  = reg_write_mem &
                   (rs_hit(rs1_id, rs1_used_id, rd_mem) | rs_hit(rs2_id, rs2_used_id, rd_mem));
        // Without forwarding the register file's write-through covers only WB
        hazard    = FORWARDING ? load_use : (raw_ex | raw_mem);
        bubble_id = ~instr_valid_i | illegal_id_o | taken | hazard;
    end

    // Forwarding select: MEM result has priority over the older WB result
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FORWARDING) begin
            if (reg_write_mem && rd_mem != '0 && rd_mem == rs1_ex) begin
                fwd_a = FWD_MEM;
            end else if (reg_write_wb && rd_wb != '0 && rd_wb == rs1_ex) begin
                fwd_a = FWD_WB;
            end
            if (reg_write_mem && rd_mem != '0 && rd_mem == rs2_ex) begin
                fwd_b = FWD_MEM;
            end else if (reg_write_wb && rd_wb != '0 && rd_wb == rs2_ex) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // Pipeline registers; stalls, flushes and invalid slots inject a bubble into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ex        <= CTRL_BUBBLE;
            alu_ctrl_ex    <= '0;
            rs1_ex         <= '0;
            rs2_ex         <= '0;
            rd_ex          <= '0;
            reg_write_mem  <= 1'b0;
            mem_write_mem  <= 1'b0;
            byte_op_mem    <= 1'b0;
            result_src_mem <= RES_ALU;
            rd_mem         <= '0;
            reg_write_wb   <= 1'b0;
            result_src_wb  <= RES_ALU;
            rd_wb          <= '0;
        end else begin
            if (bubble_id) begin
                ctrl_ex     <= CTRL_BUBBLE;
                alu_ctrl_ex <= '0;
                rs1_ex      <= '0;
                rs2_ex      <= '0;
                rd_ex       <= '0;
            end else begin
                ctrl_ex     <= ctrl_id;
                alu_ctrl_ex <= alu_ctrl_id;
                // Unused fields are zeroed so immediate bits never look like a dependency
                rs1_ex      <= rs1_used_id ? rs1_id : '0;
                rs2_ex      <= rs2_used_id ? rs2_id : '0;
                rd_ex       <= ctrl_id.reg_write ? rd_id : '0;
            end
            reg_write_mem  <= ctrl_ex.reg_write;
            mem_write_mem  <= ctrl_ex.mem_write;
            byte_op_mem    <= ctrl_ex.byte_op;
            result_src_mem <= ctrl_ex.result_src;
            rd_mem         <= rd_ex;
            reg_write_wb   <= reg_write_mem;
            result_src_wb  <= result_src_mem;
            rd_wb          <= rd_mem;
        end
    end

    assign ALUControl_ex_o = alu_ctrl_ex;
    assign ALUSrc_ex_o     = ctrl_ex.alu_src;
    assign ForwardA_ex_o   = fwd_a;
    assign ForwardB_ex_o   = fwd_b;
    assign PCSrc_ex_o      = pc_src;
    assign MemWrite_mem_o  = mem_write_mem;
    assign ByteOp_mem_o    = byte_op_mem;
    assign RegWrite_wb_o   = reg_write_wb;
    assign ResultSrc_wb_o  = result_src_wb;
    assign rd_wb_o         = rd_wb;
    assign stall_if_o      = hazard & ~taken;
    assign stall_id_o      = hazard & ~taken;
    assign flush_id_o      = taken;
    assign flush_ex_o      = taken;

endmodule
